// File: rtl/rf_pkg.sv
// Shared defaults and FSM encoding for the 2-read/1-write register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_ADDR_W   = 4;
  localparam int unsigned RF_NUM_REGS = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: decode, range/zero check, write bypass, output flop.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem [NUM_REGS],
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] lookup_c;
  logic [DATA_W-1:0] read_val_c;
  logic              in_range_c;
  logic              accept_c;

  assign in_range_c = (32'(rd_addr) < NUM_REGS);
  assign accept_c   = rd_en && run;

  // Address decode; unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    lookup_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) lookup_c = mem[i];
    end
  end

  // Hardwired zero overrides bypass; bypass only applies to implemented entries.
  always_comb begin
    read_val_c = lookup_c;
    if (BYPASS && wr_fire && (wr_addr == rd_addr) && in_range_c) read_val_c = wr_data;
    if (ZERO_REG && (rd_addr == '0)) read_val_c = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept_c;
      if (accept_c) rd_data <= read_val_c;
    end
  end

endmodule

// File: rtl/register_file_2r1w.sv
// Register file with two synchronous read ports, one write port, and a
// counted clear sweep entered on reset or clear_req.
module register_file_2r1w
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd0_en,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_valid,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_valid,
  output logic              busy,
  output logic              err
);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_idx_next;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              run_c;
  logic              wr_fire_c;

  assign run_c     = (state == ST_RUN);
  assign wr_fire_c = wr_en && run_c && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
      busy    <= (state_next == ST_CLEAR);
    end
  end

  // Sweep one entry per cycle; a clear_req mid-sweep restarts from entry 0.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      ST_CLEAR: begin
        if (clear_req) begin
          clr_idx_next = '0;
        end else if (32'(clr_idx) == NUM_REGS - 1) begin
          state_next   = ST_RUN;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_next   = ST_CLEAR;
          clr_idx_next = '0;
        end
      end
    endcase
  end

  // Storage: each entry is its own flop bank, cleared by the sweep or written in RUN.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    logic [DATA_W-1:0] entry_q;

    always_ff @(posedge clk) begin
      if (!run_c) begin
        if (clr_idx == ADDR_W'(g)) entry_q <= '0;
      end else if (wr_fire_c && (wr_addr == ADDR_W'(g)) && !(ZERO_REG && (g == 0))) begin
        entry_q <= wr_data;
      end
    end

    assign mem[g] = entry_q;
  end

  // Sticky access-while-busy flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (!run_c && (wr_en || rd0_en || rd1_en)) begin
      err <= 1'b1;
    end
  end

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd0 (
    .clk     (clk),
    .reset   (reset),
    .run     (run_c),
    .rd_en   (rd0_en),
    .rd_addr (rd0_addr),
    .wr_fire (wr_fire_c),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem),
    .rd_data (rd0_data),
    .rd_valid(rd0_valid)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd1 (
    .clk     (clk),
    .reset   (reset),
    .run     (run_c),
    .rd_en   (rd1_en),
    .rd_addr (rd1_addr),
    .wr_fire (wr_fire_c),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem     (mem),
    .rd_data (rd1_data),
    .rd_valid(rd1_valid)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench: three configurations (bypass, no bypass, zero-reg with 12 entries) share one stimulus.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset, clear_req, wr_en, rd0_en, rd1_en;
  logic [3:0]  wr_addr, rd0_addr, rd1_addr;
  logic [15:0] wr_data;

  logic [15:0] rd0_data_a, rd1_data_a, rd0_data_b, rd1_data_b, rd0_data_c, rd1_data_c;
  logic        rd0_valid_a, rd1_valid_a, rd0_valid_b, rd1_valid_b, rd0_valid_c, rd1_valid_c;
  logic        busy_a, busy_b, busy_c, err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_a), .rd0_valid(rd0_valid_a),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_a), .rd1_valid(rd1_valid_a),
    .busy(busy_a), .err(err_a));

  register_file_2r1w #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_b), .rd0_valid(rd0_valid_b),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_b), .rd1_valid(rd1_valid_b),
    .busy(busy_b), .err(err_b));

  register_file_2r1w #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_c), .rd0_valid(rd0_valid_c),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_c), .rd1_valid(rd1_valid_c),
    .busy(busy_c), .err(err_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
    wr_addr = '0; rd0_addr = '0; rd1_addr = '0; wr_data = '0;

    // 1: reset, sweep length, all entries read zero
    tick();
    reset = 1'b0;
    chk("rst_rd0_valid", 32'(rd0_valid_a), 0);
    chk("rst_rd0_data", 32'(rd0_data_a), 0);
    chk("rst_err", 32'(err_a), 0);
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy_a", 32'(busy_a), 1);
      chk("sweep_busy_c", 32'(busy_c), (i < 12) ? 1 : 0);
      tick();
    end
    chk("sweep_done_a", 32'(busy_a), 0);
    chk("sweep_done_b", 32'(busy_b), 0);
    for (int i = 0; i < 16; i++) begin
      rd0_en = 1'b1; rd0_addr = 4'(i); rd1_en = 1'b1; rd1_addr = 4'(15 - i);
      tick();
      chk("init_rd0_data", 32'(rd0_data_a), 0);
      chk("init_rd0_valid", 32'(rd0_valid_a), 1);
      chk("init_rd1_data", 32'(rd1_data_a), 0);
      chk("init_rd1_valid", 32'(rd1_valid_a), 1);
    end
    rd0_en = 1'b0; rd1_en = 1'b0;
    tick();
    chk("idle_rd0_valid", 32'(rd0_valid_a), 0);
    chk("post_init_err_a", 32'(err_a), 0);
    chk("post_init_err_c", 32'(err_c), 0);

    // 2: write then read, latency 1, data holds afterwards
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd5;
    tick();
    rd0_en = 1'b0;
    chk("wr_rd_data_a", 32'(rd0_data_a), 32'h1234);
    chk("wr_rd_valid_a", 32'(rd0_valid_a), 1);
    chk("wr_rd_data_c", 32'(rd0_data_c), 32'h1234);
    tick();
    chk("hold_valid", 32'(rd0_valid_a), 0);
    chk("hold_data", 32'(rd0_data_a), 32'h1234);

    // 3: same-cycle write/read on both ports
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111;
    tick();
    wr_data = 16'hBEEF; rd0_en = 1'b1; rd0_addr = 4'd3; rd1_en = 1'b1; rd1_addr = 4'd3;
    tick();
    wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
    chk("byp_rd0_a", 32'(rd0_data_a), 32'hBEEF);
    chk("byp_rd1_a", 32'(rd1_data_a), 32'hBEEF);
    chk("nobyp_rd0_b", 32'(rd0_data_b), 32'h1111);
    chk("nobyp_rd1_b", 32'(rd1_data_b), 32'h1111);
    chk("byp_rd0_c", 32'(rd0_data_c), 32'hBEEF);
    rd0_en = 1'b1;
    tick();
    rd0_en = 1'b0;
    chk("nobyp_after_b", 32'(rd0_data_b), 32'hBEEF);

    // 4: hardwired zero entry and out-of-range accesses
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd0; rd1_en = 1'b1; rd1_addr = 4'd14;
    tick();
    rd0_en = 1'b0; rd1_en = 1'b0;
    chk("zero_rd_c", 32'(rd0_data_c), 0);
    chk("zero_rd_a", 32'(rd0_data_a), 32'hFFFF);
    chk("oor_rd_c", 32'(rd1_data_c), 0);
    chk("oor_valid_c", 32'(rd1_valid_c), 1);
    chk("zero_err_c", 32'(err_c), 0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h7777; rd0_en = 1'b1; rd0_addr = 4'd0;
    tick();
    wr_en = 1'b0; rd0_en = 1'b0;
    chk("zero_nobyp_c", 32'(rd0_data_c), 0);
    chk("zero_byp_a", 32'(rd0_data_a), 32'h7777);
    chk("zero_old_b", 32'(rd0_data_b), 32'hFFFF);
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h4242;
    tick();
    wr_en = 1'b0; rd1_en = 1'b1; rd1_addr = 4'd13;
    tick();
    rd1_en = 1'b0;
    chk("oor_wr_c", 32'(rd1_data_c), 0);
    chk("oor_wr_valid_c", 32'(rd1_valid_c), 1);
    chk("oor_wr_a", 32'(rd1_data_a), 32'h4242);
    chk("oor_err_c", 32'(err_c), 0);

    // 5: fill, clear_req, write during sweep is dropped and flagged
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'hA5A5;
      tick();
    end
    wr_en = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd9;
    tick();
    rd0_en = 1'b0;
    chk("fill_rd_a", 32'(rd0_data_a), 32'hA5A5);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy", 32'(busy_a), 1);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5A5A;
    tick();
    wr_en = 1'b0;
    chk("busy_wr_err", 32'(err_a), 1);
    cnt = 1;
    while (busy_a && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("clr_busy_len", 32'(cnt), 16);
    for (int i = 0; i < 16; i++) begin
      rd0_en = 1'b1; rd0_addr = 4'(i);
      tick();
      chk("clr_rd_data", 32'(rd0_data_a), 0);
      chk("clr_rd_valid", 32'(rd0_valid_a), 1);
    end
    rd0_en = 1'b0;

    // 6: restart sweep at index 7, then reset mid-RUN
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd3;
    tick();
    rd0_en = 1'b0;
    chk("busy_rd_valid", 32'(rd0_valid_a), 0);
    for (int i = 0; i < 6; i++) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy_a && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("restart_busy_len", 32'(cnt), 16);
    chk("err_sticky", 32'(err_a), 1);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h9999;
    tick();
    wr_en = 1'b0; rd0_en = 1'b1; rd0_addr = 4'd5; rd1_en = 1'b1; rd1_addr = 4'd5;
    tick();
    chk("pre_rst_rd0", 32'(rd0_data_a), 32'h9999);
    reset = 1'b1;
    tick();
    reset = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
    chk("mid_rst_rd0_valid", 32'(rd0_valid_a), 0);
    chk("mid_rst_rd1_valid", 32'(rd1_valid_a), 0);
    chk("mid_rst_rd0_data", 32'(rd0_data_a), 0);
    chk("mid_rst_err", 32'(err_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 1);
    cnt = 0;
    while (busy_a && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("rst_busy_len", 32'(cnt), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
